// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout on sram_clk with a 4-phase pixel strobe; fetches one pixel ahead via vga_x/vga_y,
// displays it one pixel period later, no backpressure. VGA_TEST_PATTERN_EN adds a colour-bar input pattern_en.
module vga_scanout #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int BLANK_Y = 511
) (
  input  logic        sram_clk,
  input  logic        reset_n,
  input  logic        phase_sync,
  input  logic [15:0] vga_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pattern_en,
`endif
  output logic [9:0]  vga_x,
  output logic [9:0]  vga_y,
  output logic        frame_clk,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W   = 10'(V_VIS);
  localparam logic [9:0] HS_BEG    = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG    = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] BLANK_ROW = 10'(BLANK_Y);

  function automatic logic [23:0] expand(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  logic [1:0]  phase;
  logic [9:0]  h, v;
  logic [9:0]  h_n, v_n, fh, fv;
  logic        advance;
  logic        vis_n;
  logic [23:0] rgb_n;

  // A phase_sync pulse replaces the phase-3 slot, so it can never advance the counters.
  assign advance    = (phase == 2'd3) && !phase_sync;
  assign VGA_CLK    = phase[1];
  assign VGA_SYNC_N = 1'b0;

  always_comb begin
    h_n = h + 10'd1;
    v_n = v;
    if (h == H_LAST) begin
      h_n = '0;
      v_n = (v == V_LAST) ? '0 : v + 10'd1;
    end
    fh = h_n + 10'd1;
    fv = v_n;
    if (h_n == H_LAST) begin
      fh = '0;
      fv = (v_n == V_LAST) ? '0 : v_n + 10'd1;
    end
  end

  assign vis_n = (h_n < H_VIS_W) && (v_n < V_VIS_W);

  always_comb begin
    rgb_n = 24'd0;
    if (vis_n) begin
`ifdef VGA_TEST_PATTERN_EN
      if (pattern_en)
        rgb_n = {{8{h_n[6]}}, {8{h_n[7]}}, {8{h_n[8]}}};
      else
        rgb_n = expand(vga_data);
`else
      rgb_n = expand(vga_data);
`endif
    end
  end

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase       <= 2'd0;
      h           <= '0;
      v           <= '0;
      vga_x       <= 10'd1;
      vga_y       <= '0;
      frame_clk   <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      phase <= phase_sync ? 2'd1 : phase + 2'd1;
      if (advance) begin
        h     <= h_n;
        v     <= v_n;
        vga_x <= fh;
        // Off-screen fetches go to a scratch row so blanking write-back never touches visible rows.
        vga_y       <= (fv < V_VIS_W) ? fv : BLANK_ROW;
        frame_clk   <= (v_n >= V_VIS_W);
        VGA_HS      <= !((h_n >= HS_BEG) && (h_n < HS_END));
        VGA_VS      <= !((v_n >= VS_BEG) && (v_n < VS_END));
        VGA_BLANK_N <= vis_n;
        {VGA_R, VGA_G, VGA_B} <= rgb_n;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with full horizontal timing and a shortened vertical frame (11 visible rows).
module tb_vga_scanout;

  localparam int V_VIS     = 11;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 1;
  localparam int LINE_CLKS = 3200;

  logic        sram_clk;
  logic        reset_n;
  logic        phase_sync;
  logic [15:0] vga_data;
`ifdef VGA_TEST_PATTERN_EN
  logic        pattern_en;
`endif
  logic [9:0]  vga_x, vga_y;
  logic        frame_clk, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [23:0] rgb;

  int checks = 0;
  int passed = 0;
  logic [23:0] exp_q[$];

  logic [1:0] bph;
  bit         inj_req = 1'b0;
  bit         inj_done = 1'b0;
  logic [1:0] inj_phase = 2'd0;

  assign rgb = {VGA_R, VGA_G, VGA_B};

  vga_scanout #(.V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)) dut (
    .sram_clk    (sram_clk),
    .reset_n     (reset_n),
    .phase_sync  (phase_sync),
    .vga_data    (vga_data),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_en  (pattern_en),
`endif
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .frame_clk   (frame_clk),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  initial begin
    sram_clk = 1'b0;
    forever #5 sram_clk = ~sram_clk;
  end

  // Controller stand-in: pulses phase_sync in phase 0, or once in a requested phase.
  always @(posedge sram_clk or negedge reset_n)
    if (!reset_n) bph <= 2'd0;
    else          bph <= phase_sync ? 2'd1 : bph + 2'd1;

  initial begin
    phase_sync = 1'b0;
    forever begin
      @(negedge sram_clk);
      if (!reset_n) phase_sync = 1'b0;
      else if (inj_req && bph == inj_phase) begin
        phase_sync = 1'b1;
        inj_req    = 1'b0;
        inj_done   = 1'b1;
      end else phase_sync = (bph == 2'd0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_x(input logic [9:0] x, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (vga_x == x) begin
        ok = 1'b1;
        break;
      end
      @(negedge sram_clk);
    end
  endtask

  task automatic wait_x_change(input int bound, output bit ok);
    logic [9:0] x0;
    x0 = vga_x;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge sram_clk);
      if (vga_x != x0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset_n  = 1'b0;
    vga_data = 16'hFFFF;
    repeat (4) @(negedge sram_clk);
    reset_n = 1'b1;
    repeat (60) @(negedge sram_clk);
    checks++;
    if (VGA_BLANK_N !== 1'b1 || rgb !== 24'hFFFFFF)
      $display("FAIL pre_reset_visible: blank_n=%b rgb=%h, expected 1 ffffff", VGA_BLANK_N, rgb);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N, frame_clk, VGA_CLK, VGA_SYNC_N} !== 6'b110000)
      $display("FAIL reset_ctrl: hs,vs,blank_n,frame_clk,vga_clk,sync_n=%b, expected 110000",
               {VGA_HS, VGA_VS, VGA_BLANK_N, frame_clk, VGA_CLK, VGA_SYNC_N});
    else passed++;
    checks++;
    if (rgb !== 24'h0) $display("FAIL reset_rgb: got %h expected 000000", rgb);
    else passed++;
    checks++;
    if (vga_x !== 10'd1 || vga_y !== 10'd0)
      $display("FAIL reset_fetch: x=%0d y=%0d expected 1 0", vga_x, vga_y);
    else passed++;
    @(negedge sram_clk);
    reset_n = 1'b1;
    @(negedge sram_clk);
    checks++;
    if (rgb !== 24'h0 || VGA_BLANK_N !== 1'b0 || vga_x !== 10'd1)
      $display("FAIL first_pixel: rgb=%h blank_n=%b x=%0d, expected 000000 0 1", rgb, VGA_BLANK_N, vga_x);
    else passed++;
    wait_x_change(8, ok);
    checks++;
    if (!ok || rgb !== 24'hFFFFFF || vga_x !== 10'd2)
      $display("FAIL second_pixel: ok=%b rgb=%h x=%0d, expected 1 ffffff 2", ok, rgb, vga_x);
    else passed++;
  endtask

  task automatic test_phase_realign();
    bit ok, got;
    logic [9:0] xb;
    int k;
    for (int p = 2; p <= 3; p++) begin
      inj_done  = 1'b0;
      inj_phase = 2'(p);
      inj_req   = 1'b1;
      got       = 1'b0;
      xb        = '0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge sram_clk);
        xb = vga_x;
        @(posedge sram_clk);
        if (inj_done) got = 1'b1;
      end
      @(negedge sram_clk);
      checks++;
      if (!got || VGA_CLK !== 1'b0 || vga_x !== xb)
        $display("FAIL sync_at_phase%0d: injected=%b vga_clk=%b x=%0d, expected 1 0 %0d", p, got, VGA_CLK, vga_x, xb);
      else passed++;
      k = 0;
      xb = vga_x;
      while (vga_x == xb && k < 10) begin
        @(negedge sram_clk);
        k++;
      end
      checks++;
      if (k != 3) $display("FAIL realign_first_period_p%0d: %0d clks expected 3", p, k);
      else passed++;
      k = 0;
      xb = vga_x;
      while (vga_x == xb && k < 10) begin
        @(negedge sram_clk);
        k++;
      end
      checks++;
      if (k != 4) $display("FAIL realign_next_period_p%0d: %0d clks expected 4", p, k);
      else passed++;
    end
  endtask

  task automatic test_line_timing();
    bit found, prev;
    int n;
    found = 1'b0;
    prev  = VGA_HS;
    for (int i = 0; i < 3400 && !found; i++) begin
      @(negedge sram_clk);
      if (prev && !VGA_HS) found = 1'b1;
      prev = VGA_HS;
    end
    checks++;
    if (!found || vga_x !== 10'd657 || VGA_BLANK_N !== 1'b0)
      $display("FAIL hs_start: found=%b x=%0d blank_n=%b, expected 1 657 0", found, vga_x, VGA_BLANK_N);
    else passed++;
    n = 0;
    while (VGA_HS == 1'b0 && n < 1000) begin
      @(negedge sram_clk);
      n++;
    end
    checks++;
    if (n != 384 || vga_x !== 10'd753)
      $display("FAIL hs_width: %0d clks x=%0d, expected 384 753", n, vga_x);
    else passed++;
    while (VGA_HS == 1'b1 && n < 4000) begin
      @(negedge sram_clk);
      n++;
    end
    checks++;
    if (n != LINE_CLKS) $display("FAIL line_period: %0d clks expected %0d", n, LINE_CLKS);
    else passed++;
    found = 1'b0;
    prev  = VGA_BLANK_N;
    for (int i = 0; i < 3400 && !found; i++) begin
      @(negedge sram_clk);
      if (prev && !VGA_BLANK_N) found = 1'b1;
      prev = VGA_BLANK_N;
    end
    n = 0;
    while (found && VGA_BLANK_N == 1'b0 && n < 1000) begin
      @(negedge sram_clk);
      n++;
    end
    checks++;
    if (!found || n != 640) $display("FAIL hblank_width: found=%b %0d clks, expected 1 640", found, n);
    else passed++;
  endtask

  task automatic test_rgb_expand();
    bit ok;
    logic [9:0]  fx  [6];
    logic [15:0] dat [6];
    logic [23:0] ex  [6];
    logic [23:0] e;
    fx  = '{10'd5, 10'd6, 10'd7, 10'd8, 10'd639, 10'd640};
    dat = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410, 16'h8410, 16'hF800};
    ex  = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284, 24'h848284, 24'h000000};
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (vga_x == 10'd5 && vga_y == 10'd10) begin
        ok = 1'b1;
        break;
      end
      @(negedge sram_clk);
    end
    checks++;
    if (!ok) $display("FAIL reach_fetch_5_10: x=%0d y=%0d, expected 5 10", vga_x, vga_y);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      wait_x(fx[i], 3300, ok);
      vga_data = dat[i];
      exp_q.push_back(ex[i]);
      if (ok) wait_x_change(8, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || rgb !== e || vga_y !== 10'd10)
        $display("FAIL rgb_pixel_%0d: ok=%b rgb=%h y=%0d, expected 1 %h 10", fx[i], ok, rgb, vga_y, e);
      else passed++;
    end
    vga_data = 16'hFFFF;
  endtask

  task automatic test_blank_row();
    bit found, prev;
    logic [9:0] px, py;
    found = 1'b0;
    prev  = frame_clk;
    px    = vga_x;
    py    = vga_y;
    for (int i = 0; i < 12000 && !found; i++) begin
      px = vga_x;
      py = vga_y;
      @(negedge sram_clk);
      if (!prev && frame_clk) found = 1'b1;
      prev = frame_clk;
    end
    checks++;
    if (!found || px !== 10'd0 || py !== 10'd511)
      $display("FAIL fetch_before_vblank: found=%b x=%0d y=%0d, expected 1 0 511", found, px, py);
    else passed++;
    checks++;
    if (vga_x !== 10'd1 || vga_y !== 10'd511)
      $display("FAIL frame_clk_rise_pos: x=%0d y=%0d, expected 1 511", vga_x, vga_y);
    else passed++;
    checks++;
    if (VGA_BLANK_N !== 1'b0 || rgb !== 24'h0 || VGA_VS !== 1'b1)
      $display("FAIL vblank_row: blank_n=%b rgb=%h vs=%b, expected 0 000000 1", VGA_BLANK_N, rgb, VGA_VS);
    else passed++;
  endtask

  task automatic test_frame_timing();
    int n;
    n = 0;
    while (VGA_VS == 1'b1 && n < 8000) begin
      @(negedge sram_clk);
      n++;
    end
    checks++;
    if (n != V_FP * LINE_CLKS || vga_x !== 10'd1)
      $display("FAIL vs_start: %0d clks x=%0d, expected %0d 1", n, vga_x, V_FP * LINE_CLKS);
    else passed++;
    n = 0;
    while (VGA_VS == 1'b0 && n < 10000) begin
      @(negedge sram_clk);
      n++;
    end
    checks++;
    if (n != V_SYNC * LINE_CLKS) $display("FAIL vs_width: %0d clks expected %0d", n, V_SYNC * LINE_CLKS);
    else passed++;
    n = 0;
    while (frame_clk == 1'b1 && n < 8000) begin
      @(negedge sram_clk);
      n++;
    end
    checks++;
    if (n != V_BP * LINE_CLKS) $display("FAIL back_porch: %0d clks expected %0d", n, V_BP * LINE_CLKS);
    else passed++;
    checks++;
    if (vga_x !== 10'd1 || vga_y !== 10'd0 || VGA_BLANK_N !== 1'b1 || rgb !== 24'hFFFFFF)
      $display("FAIL frame_wrap: x=%0d y=%0d blank_n=%b rgb=%h, expected 1 0 1 ffffff",
               vga_x, vga_y, VGA_BLANK_N, rgb);
    else passed++;
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    bit ok;
    logic [9:0]  dx [8];
    logic [23:0] ex [8];
    logic [23:0] e;
    dx = '{10'd64, 10'd127, 10'd128, 10'd448, 10'd511, 10'd512, 10'd639, 10'd640};
    ex = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h000000};
    pattern_en = 1'b1;
    vga_data   = 16'h001F;
    for (int i = 0; i < 8; i++) begin
      wait_x(dx[i], 3300, ok);
      exp_q.push_back(ex[i]);
      if (ok) wait_x_change(8, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || rgb !== e) $display("FAIL pattern_h%0d: ok=%b rgb=%h, expected 1 %h", dx[i], ok, rgb, e);
      else passed++;
    end
    pattern_en = 1'b0;
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    vga_data = 16'hFFFF;
`ifdef VGA_TEST_PATTERN_EN
    pattern_en = 1'b0;
`endif
    test_reset();
    test_phase_realign();
    test_line_timing();
    test_rgb_expand();
    test_blank_row();
    test_frame_timing();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
